// File: rtl/screen_sequencer_if.sv
// Signal bundle between the game's main state machine, the VGA timing block and
// the screen sequencer. The sequencer uses the slave modport.
interface screen_sequencer_if;
    logic [5:0] state_bin;
    logic       rst_sys;
    logic       vblnk;
    logic [1:0] screen_sel;
    logic       screen_blank;
    logic       game_rst;
    logic       state_err;
    logic [1:0] fsm_state;

    // No handshake: every signal is a level, sampled on each rising pixel clock.
    modport master (
        output state_bin, rst_sys, vblnk,
        input  screen_sel, screen_blank, game_rst, state_err, fsm_state
    );

    modport slave (
        input  state_bin, rst_sys, vblnk,
        output screen_sel, screen_blank, game_rst, state_err, fsm_state
    );
endinterface

// File: rtl/screen_sequencer.sv
// Frame-aligned screen selection, game-core reset pulse and illegal-state flag.
// Define SCREEN_SEQ_BLANK_EN to blank the output for HOLD_FRAMES frames on a screen change.
module screen_sequencer #(
    parameter int HOLD_FRAMES = 2,
    parameter int RST_FRAMES  = 1
) (
    input logic               clk,
    input logic               rst_n,
    screen_sequencer_if.slave sif
);
    typedef enum logic [1:0] {SHOW = 2'd0, PENDING = 2'd1, BLANK = 2'd2} state_e;

    localparam logic [3:0] RST_LOAD = 4'(RST_FRAMES);

    logic       vblnk_q;
    logic [5:0] sb_q;
    logic       rst_sys_q;
    logic [1:0] target_q, target_d;
    logic       err_q, err_d;
    state_e     state_q, state_d;
    logic [1:0] sel_q, sel_d;
    logic       arm_q, arm_d;
    logic       grst_q, grst_d;
    logic [3:0] rcnt_q, rcnt_d;
    logic       vs_edge, sb_stable, rst_rise;

`ifdef SCREEN_SEQ_BLANK_EN
    localparam logic [3:0] HOLD_LOAD = 4'(HOLD_FRAMES);
    logic       blank_q, blank_d;
    logic [3:0] hold_q, hold_d;
`endif

    // Present in the elaborated hierarchy only when a frame count is outside 1..15.
    if (HOLD_FRAMES < 1 || HOLD_FRAMES > 15 || RST_FRAMES < 1 || RST_FRAMES > 15) begin : g_frames_out_of_range
    end

    assign vs_edge   = sif.vblnk & ~vblnk_q;
    assign sb_stable = (sif.state_bin == sb_q);
    assign rst_rise  = sif.rst_sys & ~rst_sys_q;

    // Decode: step/step2 keep the current target, anything not one-hot is illegal.
    always_comb begin
        target_d = target_q;
        err_d    = err_q;
        if (sb_stable) begin
            case (sif.state_bin)
                6'b000001: target_d = 2'd0;
                6'b000010: target_d = 2'd1;
                6'b000100: target_d = 2'd2;
                6'b010000: target_d = 2'd3;
                6'b001000, 6'b100000: target_d = target_q;
                default:   err_d = 1'b1;
            endcase
        end
    end

    always_comb begin
        state_d = state_q;
        sel_d   = sel_q;
`ifdef SCREEN_SEQ_BLANK_EN
        blank_d = blank_q;
        hold_d  = hold_q;
`endif
        case (state_q)
            SHOW: begin
                if (target_q != sel_q) state_d = PENDING;
            end
            PENDING: begin
                if (target_q == sel_q) begin
                    state_d = SHOW;
                end else if (vs_edge) begin
`ifdef SCREEN_SEQ_BLANK_EN
                    blank_d = 1'b1;
                    hold_d  = HOLD_LOAD;
                    state_d = BLANK;
`else
                    sel_d   = target_q;
                    state_d = SHOW;
`endif
                end
            end
            BLANK: begin
`ifdef SCREEN_SEQ_BLANK_EN
                // The interval always runs to completion and picks up the latest target.
                if (vs_edge) begin
                    if (hold_q <= 4'd1) begin
                        sel_d   = target_q;
                        blank_d = 1'b0;
                        hold_d  = 4'd0;
                        state_d = SHOW;
                    end else begin
                        hold_d  = hold_q - 4'd1;
                    end
                end
`else
                state_d = SHOW;
`endif
            end
            default: state_d = SHOW;
        endcase
    end

    always_comb begin
        arm_d  = arm_q;
        grst_d = grst_q;
        rcnt_d = rcnt_q;
        if (grst_q) begin
            if (rst_rise) begin
                rcnt_d = RST_LOAD;
            end else if (vs_edge) begin
                if (rcnt_q <= 4'd1) begin
                    grst_d = 1'b0;
                    rcnt_d = 4'd0;
                end else begin
                    rcnt_d = rcnt_q - 4'd1;
                end
            end
        end else if (arm_q && vs_edge) begin
            grst_d = 1'b1;
            rcnt_d = RST_LOAD;
            arm_d  = 1'b0;
        end else if (rst_rise) begin
            arm_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vblnk_q   <= 1'b0;
            sb_q      <= 6'b000001;
            rst_sys_q <= 1'b0;
            target_q  <= 2'd0;
            err_q     <= 1'b0;
            state_q   <= SHOW;
            sel_q     <= 2'd0;
            arm_q     <= 1'b0;
            grst_q    <= 1'b0;
            rcnt_q    <= 4'd0;
        end else begin
            vblnk_q   <= sif.vblnk;
            sb_q      <= sif.state_bin;
            rst_sys_q <= sif.rst_sys;
            target_q  <= target_d;
            err_q     <= err_d;
            state_q   <= state_d;
            sel_q     <= sel_d;
            arm_q     <= arm_d;
            grst_q    <= grst_d;
            rcnt_q    <= rcnt_d;
        end
    end

`ifdef SCREEN_SEQ_BLANK_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            blank_q <= 1'b0;
            hold_q  <= 4'd0;
        end else begin
            blank_q <= blank_d;
            hold_q  <= hold_d;
        end
    end
    assign sif.screen_blank = blank_q;
`else
    assign sif.screen_blank = 1'b0;
`endif

    assign sif.screen_sel = sel_q;
    assign sif.game_rst   = grst_q;
    assign sif.state_err  = err_q;
    assign sif.fsm_state  = state_q;
endmodule
